// File: rtl/dmni_ni_queued_pkg.sv
// rtl/dmni_ni_queued_pkg.sv - shared types, register indices and IRQ bit positions for the queued DMNI NI
package dmni_ni_queued_pkg;

    localparam int NI_Q_ADDR_W = 6;

    // Word indices of the memory-mapped registers
    typedef enum logic [NI_Q_ADDR_W-1:0] {
        STATUS             = 6'd0,
        IRQ_STATUS         = 6'd1,
        IRQ_MASK           = 6'd2,
        IRQ_CLEAR          = 6'd3,
        ADDRESS_REG        = 6'd4,
        MANYCORE_SIZE      = 6'd5,
        TASKS_PER_PE_REG   = 6'd6,
        IMEM_PAGE_SZ_REG   = 6'd7,
        DMEM_PAGE_SZ_REG   = 6'd8,
        HERMES_START       = 6'd9,
        HERMES_OPERATION   = 6'd10,
        HERMES_SIZE        = 6'd11,
        HERMES_SIZE_2      = 6'd12,
        HERMES_ADDRESS     = 6'd13,
        HERMES_ADDRESS_2   = 6'd14,
        BR_SERVICE         = 6'd15,
        BR_KSVC            = 6'd16,
        BR_TARGET          = 6'd17,
        BR_PRODUCER        = 6'd18,
        BR_PAYLOAD         = 6'd19,
        BR_START           = 6'd20,
        BR_SVC_KSVC        = 6'd21,
        BR_SVC_PRODUCER    = 6'd22,
        BR_SVC_TARGET      = 6'd23,
        BR_SVC_PAYLOAD     = 6'd24,
        BR_SVC_POP         = 6'd25,
        BR_MON_CLEAR       = 6'd26,
        PENDING_SVC        = 6'd28,
        RELEASE_PERIPHERAL = 6'd29,
        BR_MON_PTR_BASE    = 6'd32
    } ni_q_reg_e;

    // IRQ_STATUS / IRQ_MASK / IRQ_CLEAR bit positions
    localparam int IRQ_HERMES_RX   = 0;
    localparam int IRQ_BR_SVC_RX   = 1;
    localparam int IRQ_PENDING_SVC = 2;
    localparam int IRQ_TX_DRAINED  = 3;
    localparam int IRQ_TX_OVF      = 4;
    localparam int IRQ_BUSY_REJ    = 5;  // clear-only; reported in STATUS[5]
    localparam int IRQ_W           = 5;

    typedef enum logic {
        HERMES_SEND    = 1'b0,
        HERMES_RECEIVE = 1'b1
    } hermes_op_t;

    typedef struct packed {
        logic [1:0]  service;
        logic [7:0]  ksvc;
        logic [15:0] target;
        logic [15:0] producer;
        logic [31:0] payload;
    } brlite_out_t;

    typedef struct packed {
        logic [7:0]  ksvc;
        logic [15:0] producer;
        logic [15:0] target;
        logic [31:0] payload;
    } brlite_svc_t;

endpackage

// File: rtl/dmni_br_tx_fifo.sv
// rtl/dmni_br_tx_fifo.sv - synchronous FIFO holding outgoing BrLite packets
// Ports: clk_i/rst_i (sync active-high); push_i+data_i enqueue; pop_i dequeues head;
// full_o/empty_o/count_o status; head_o is the oldest entry.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module dmni_br_tx_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic             full_o,
    output logic             empty_o,
    output logic [PTR_W:0]   count_o,
    output logic [WIDTH-1:0] head_o
);

    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic             pop_eff;
    logic             push_eff;

    assign empty_o  = (count == '0);
    assign full_o   = (count == FULL_CNT);
    assign count_o  = count;
    assign head_o   = mem[rd_ptr];
    assign pop_eff  = pop_i & ~empty_o;
    assign push_eff = push_i & (~full_o | pop_eff);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push_eff) begin
                mem[wr_ptr] <= data_i;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop_eff) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_eff, pop_eff})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/dmni_ni_queued.sv
// rtl/dmni_ni_queued.sv - DMNI NI control block with BrLite TX queue, maskable IRQs and monitor pointers
// Ports: clk_i/rst_i (sync active-high); cfg_* word-indexed MMR port with registered read data;
// irq_o; hermes_* Hermes engine control/status; br_req_o/br_ack_i/br_data_o TX queue head;
// br_svc_* service packet pop; br_mon_* monitor pointers and clear handshake.
module dmni_ni_queued
    import dmni_ni_queued_pkg::*;
#(
    parameter int          N_PE_X       = 2,
    parameter int          N_PE_Y       = 2,
    parameter int          TASKS_PER_PE = 1,
    parameter int          IMEM_PAGE_SZ = 32768,
    parameter int          DMEM_PAGE_SZ = 32768,
    parameter logic [15:0] ADDRESS      = 16'h0,
    parameter int          BR_TX_DEPTH  = 4,
    parameter int          N_MON        = 2
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   cfg_en_i,
    input  logic                   cfg_we_i,
    input  logic [NI_Q_ADDR_W-1:0] cfg_addr_i,
    input  logic [31:0]            cfg_data_i,
    output logic [31:0]            cfg_data_o,
    output logic                   irq_o,
    input  logic                   hermes_send_active_i,
    input  logic                   hermes_receive_active_i,
    input  logic                   hermes_receive_available_i,
    output logic                   hermes_start_o,
    output hermes_op_t             hermes_operation_o,
    output logic [31:0]            hermes_size_o,
    output logic [31:0]            hermes_size_2_o,
    output logic [31:0]            hermes_address_o,
    output logic [31:0]            hermes_address_2_o,
    output logic                   br_req_o,
    input  logic                   br_ack_i,
    output brlite_out_t            br_data_o,
    input  logic                   br_svc_rx_i,
    output logic                   br_svc_ack_o,
    input  brlite_svc_t            br_svc_data_i,
    output logic [N_MON*32-1:0]    br_mon_ptrs_o,
    output logic                   br_mon_clear_o,
    input  logic                   br_mon_clear_ack_i,
    output logic [31:0]            br_mon_task_clear_o
);

    localparam int CNT_W = $clog2(BR_TX_DEPTH) + 1;

    logic                   wr_en;
    logic                   rd_en;
    logic [31:0]            rd_data;
    logic [31:0]            clr_mask;

    brlite_out_t            stage_q;
    logic                   push;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic [CNT_W-1:0]       fifo_count;
    logic [$bits(brlite_out_t)-1:0] fifo_head;
    logic                   tx_ovf_set;
    logic                   tx_drained_set;

    logic                   tx_ovf_q;
    logic                   tx_drained_q;
    logic                   busy_rej_q;
    logic                   pending_svc_q;
    logic                   release_q;
    logic [IRQ_W-1:0]       irq_mask_q;
    logic [IRQ_W-1:0]       irq_status;

    logic                   start_req;
    logic                   busy_rej_set;
    logic                   hermes_start_q;
    hermes_op_t             hermes_op_q;
    logic [31:0]            hermes_size_q;
    logic [31:0]            hermes_size_2_q;
    logic [31:0]            hermes_addr_q;
    logic [31:0]            hermes_addr_2_q;

    logic                   svc_ack_q;
    logic                   mon_clear_q;
    logic [31:0]            mon_task_q;
    logic [31:0]            mon_ptr_q [N_MON];
    logic [NI_Q_ADDR_W-1:0] mon_idx;
    logic                   mon_sel;

    assign wr_en    = cfg_en_i & cfg_we_i;
    assign rd_en    = cfg_en_i & ~cfg_we_i;
    assign clr_mask = (wr_en && cfg_addr_i == IRQ_CLEAR) ? cfg_data_i : 32'h0;

    assign mon_idx  = cfg_addr_i - BR_MON_PTR_BASE;
    assign mon_sel  = (cfg_addr_i >= BR_MON_PTR_BASE) && (mon_idx < NI_Q_ADDR_W'(N_MON));

    // ---------------- BrLite TX queue ----------------
    // stage_q is read before this edge's write lands, so a push sends the old staging value.
    assign push = wr_en && (cfg_addr_i == BR_START) && cfg_data_i[0];

    dmni_br_tx_fifo #(
        .DEPTH (BR_TX_DEPTH),
        .WIDTH ($bits(brlite_out_t))
    ) u_tx_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (push),
        .data_i  (stage_q),
        .pop_i   (br_ack_i),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count),
        .head_o  (fifo_head)
    );

    // When full the FIFO is non-empty, so a same-cycle ack always makes room.
    assign tx_ovf_set     = push & fifo_full & ~br_ack_i;
    assign tx_drained_set = br_ack_i & ~push & (fifo_count == CNT_W'(1));

    assign br_req_o  = ~fifo_empty;
    assign br_data_o = fifo_head;

    // ---------------- IRQ ----------------
    assign irq_status = {tx_ovf_q, tx_drained_q, pending_svc_q, br_svc_rx_i, hermes_receive_available_i};
    assign irq_o      = |(irq_status & irq_mask_q);

    // ---------------- Hermes ----------------
    assign start_req    = wr_en && (cfg_addr_i == HERMES_START) && cfg_data_i[0];
    assign busy_rej_set = start_req & hermes_send_active_i;

    assign hermes_start_o     = hermes_start_q;
    assign hermes_operation_o = hermes_op_q;
    assign hermes_size_o      = hermes_size_q;
    assign hermes_size_2_o    = hermes_size_2_q;
    assign hermes_address_o   = hermes_addr_q;
    assign hermes_address_2_o = hermes_addr_2_q;

    assign br_svc_ack_o        = svc_ack_q;
    assign br_mon_clear_o      = mon_clear_q;
    assign br_mon_task_clear_o = mon_task_q;

    for (genvar g = 0; g < N_MON; g++) begin : g_mon_out
        assign br_mon_ptrs_o[g*32 +: 32] = mon_ptr_q[g];
    end

    // ---------------- Register state ----------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stage_q         <= '0;
            tx_ovf_q        <= 1'b0;
            tx_drained_q    <= 1'b0;
            busy_rej_q      <= 1'b0;
            pending_svc_q   <= 1'b0;
            release_q       <= 1'b0;
            irq_mask_q      <= '0;
            hermes_start_q  <= 1'b0;
            hermes_op_q     <= HERMES_SEND;
            hermes_size_q   <= '0;
            hermes_size_2_q <= '0;
            hermes_addr_q   <= '0;
            hermes_addr_2_q <= '0;
            svc_ack_q       <= 1'b0;
            mon_clear_q     <= 1'b0;
            mon_task_q      <= '0;
            for (int i = 0; i < N_MON; i++) begin
                mon_ptr_q[i] <= '0;
            end
        end else begin
            // Sticky events: a set in the same cycle as its clear wins.
            tx_ovf_q       <= tx_ovf_set     | (tx_ovf_q     & ~clr_mask[IRQ_TX_OVF]);
            tx_drained_q   <= tx_drained_set | (tx_drained_q & ~clr_mask[IRQ_TX_DRAINED]);
            busy_rej_q     <= busy_rej_set   | (busy_rej_q   & ~clr_mask[IRQ_BUSY_REJ]);

            hermes_start_q <= start_req & ~hermes_send_active_i;
            svc_ack_q      <= wr_en && (cfg_addr_i == BR_SVC_POP) && cfg_data_i[0] && !svc_ack_q;

            if (br_mon_clear_ack_i) begin
                mon_clear_q <= 1'b0;
            end else if (wr_en && (cfg_addr_i == BR_MON_CLEAR) && !mon_clear_q) begin
                mon_clear_q <= 1'b1;
                mon_task_q  <= cfg_data_i;
            end

            if (wr_en) begin
                for (int i = 0; i < N_MON; i++) begin
                    if (mon_sel && mon_idx == NI_Q_ADDR_W'(i)) begin
                        mon_ptr_q[i] <= cfg_data_i;
                    end
                end
                case (cfg_addr_i)
                    IRQ_MASK:           irq_mask_q       <= cfg_data_i[IRQ_W-1:0];
                    HERMES_OPERATION:   hermes_op_q      <= hermes_op_t'(cfg_data_i[0]);
                    HERMES_SIZE:        hermes_size_q    <= cfg_data_i;
                    HERMES_SIZE_2:      hermes_size_2_q  <= cfg_data_i;
                    HERMES_ADDRESS:     hermes_addr_q    <= cfg_data_i;
                    HERMES_ADDRESS_2:   hermes_addr_2_q  <= cfg_data_i;
                    BR_SERVICE:         stage_q.service  <= cfg_data_i[1:0];
                    BR_KSVC:            stage_q.ksvc     <= cfg_data_i[7:0];
                    BR_TARGET:          stage_q.target   <= cfg_data_i[15:0];
                    BR_PRODUCER:        stage_q.producer <= cfg_data_i[15:0];
                    BR_PAYLOAD:         stage_q.payload  <= cfg_data_i;
                    PENDING_SVC:        pending_svc_q    <= cfg_data_i[0];
                    RELEASE_PERIPHERAL: release_q        <= cfg_data_i[0];
                    default: ;
                endcase
            end
        end
    end

    // ---------------- Read mux ----------------
    always_comb begin
        rd_data = 32'h0;
        if (mon_sel) begin
            for (int i = 0; i < N_MON; i++) begin
                if (mon_idx == NI_Q_ADDR_W'(i)) begin
                    rd_data = mon_ptr_q[i];
                end
            end
        end else begin
            case (cfg_addr_i)
                STATUS:             rd_data = {16'h0, 8'(fifo_count), 2'b00, busy_rej_q, release_q,
                                               mon_clear_q, fifo_full, hermes_receive_active_i,
                                               hermes_send_active_i};
                IRQ_STATUS:         rd_data = {27'h0, irq_status};
                IRQ_MASK:           rd_data = {27'h0, irq_mask_q};
                ADDRESS_REG:        rd_data = {16'h0, ADDRESS};
                MANYCORE_SIZE:      rd_data = {7'h0, 9'(N_PE_X), 7'h0, 9'(N_PE_Y)};
                TASKS_PER_PE_REG:   rd_data = 32'(TASKS_PER_PE);
                IMEM_PAGE_SZ_REG:   rd_data = 32'(IMEM_PAGE_SZ);
                DMEM_PAGE_SZ_REG:   rd_data = 32'(DMEM_PAGE_SZ);
                HERMES_OPERATION:   rd_data = {31'h0, hermes_op_q};
                HERMES_SIZE:        rd_data = hermes_size_q;
                HERMES_SIZE_2:      rd_data = hermes_size_2_q;
                HERMES_ADDRESS:     rd_data = hermes_addr_q;
                HERMES_ADDRESS_2:   rd_data = hermes_addr_2_q;
                BR_SVC_KSVC:        rd_data = {24'h0, br_svc_data_i.ksvc};
                BR_SVC_PRODUCER:    rd_data = {16'h0, br_svc_data_i.producer};
                BR_SVC_TARGET:      rd_data = {16'h0, br_svc_data_i.target};
                BR_SVC_PAYLOAD:     rd_data = br_svc_data_i.payload;
                BR_MON_CLEAR:       rd_data = mon_task_q;
                PENDING_SVC:        rd_data = {31'h0, pending_svc_q};
                RELEASE_PERIPHERAL: rd_data = {31'h0, release_q};
                default:            rd_data = 32'h0;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cfg_data_o <= 32'h0;
        end else if (rd_en) begin
            cfg_data_o <= rd_data;
        end
    end

endmodule

// File: tb/tb_dmni_ni_queued.sv
// tb/tb_dmni_ni_queued.sv - self-checking bench for dmni_ni_queued against a queue-based reference model
module tb_dmni_ni_queued;
    import dmni_ni_queued_pkg::*;

    localparam int DEPTH = 4;
    localparam int NMON  = 2;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        cfg_en_i, cfg_we_i;
    logic [5:0]  cfg_addr_i;
    logic [31:0] cfg_data_i;
    logic [31:0] cfg_data_o;
    logic        irq_o;
    logic        hermes_send_active_i, hermes_receive_active_i, hermes_receive_available_i;
    logic        hermes_start_o;
    hermes_op_t  hermes_operation_o;
    logic [31:0] hermes_size_o, hermes_size_2_o, hermes_address_o, hermes_address_2_o;
    logic        br_req_o, br_ack_i;
    brlite_out_t br_data_o;
    logic        br_svc_rx_i, br_svc_ack_o;
    brlite_svc_t br_svc_data_i;
    logic [NMON*32-1:0] br_mon_ptrs_o;
    logic        br_mon_clear_o, br_mon_clear_ack_i;
    logic [31:0] br_mon_task_clear_o;

    int errors = 0;
    int checks = 0;

    // Reference model state
    brlite_out_t mq[$];
    logic        m_ovf, m_drained;

    dmni_ni_queued #(
        .N_PE_X(3), .N_PE_Y(2), .ADDRESS(16'h0102), .BR_TX_DEPTH(DEPTH), .N_MON(NMON)
    ) dut (
        .clk_i(clk), .rst_i(rst_i),
        .cfg_en_i(cfg_en_i), .cfg_we_i(cfg_we_i), .cfg_addr_i(cfg_addr_i),
        .cfg_data_i(cfg_data_i), .cfg_data_o(cfg_data_o), .irq_o(irq_o),
        .hermes_send_active_i(hermes_send_active_i),
        .hermes_receive_active_i(hermes_receive_active_i),
        .hermes_receive_available_i(hermes_receive_available_i),
        .hermes_start_o(hermes_start_o), .hermes_operation_o(hermes_operation_o),
        .hermes_size_o(hermes_size_o), .hermes_size_2_o(hermes_size_2_o),
        .hermes_address_o(hermes_address_o), .hermes_address_2_o(hermes_address_2_o),
        .br_req_o(br_req_o), .br_ack_i(br_ack_i), .br_data_o(br_data_o),
        .br_svc_rx_i(br_svc_rx_i), .br_svc_ack_o(br_svc_ack_o), .br_svc_data_i(br_svc_data_i),
        .br_mon_ptrs_o(br_mon_ptrs_o), .br_mon_clear_o(br_mon_clear_o),
        .br_mon_clear_ack_i(br_mon_clear_ack_i), .br_mon_task_clear_o(br_mon_task_clear_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [79:0] got, input logic [79:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [5:0] a, input logic [31:0] d);
        cfg_en_i = 1'b1; cfg_we_i = 1'b1; cfg_addr_i = a; cfg_data_i = d;
        cycle();
        cfg_en_i = 1'b0; cfg_we_i = 1'b0;
    endtask

    task automatic rd(input logic [5:0] a, output logic [31:0] d);
        cfg_en_i = 1'b1; cfg_we_i = 1'b0; cfg_addr_i = a;
        cycle();
        cfg_en_i = 1'b0;
        d = cfg_data_o;
    endtask

    function automatic brlite_out_t rand_pkt(input logic [31:0] payload);
        brlite_out_t p;
        p.service  = 2'($urandom);
        p.ksvc     = 8'($urandom);
        p.target   = 16'($urandom);
        p.producer = 16'($urandom);
        p.payload  = payload;
        return p;
    endfunction

    // Stage a packet then hit BR_START, optionally with a same-cycle router ack.
    task automatic push_pkt(input brlite_out_t p, input logic ack);
        wr(BR_SERVICE,  {30'h0, p.service});
        wr(BR_KSVC,     {24'h0, p.ksvc});
        wr(BR_TARGET,   {16'h0, p.target});
        wr(BR_PRODUCER, {16'h0, p.producer});
        wr(BR_PAYLOAD,  p.payload);
        br_ack_i = ack;
        wr(BR_START, 32'h1);
        br_ack_i = 1'b0;
        if (ack && mq.size() != 0) mq.delete(0);
        if (mq.size() < DEPTH) mq.push_back(p);
        else m_ovf = 1'b1;
    endtask

    task automatic ack_only();
        br_ack_i = 1'b1;
        cycle();
        br_ack_i = 1'b0;
        if (mq.size() != 0) begin
            mq.delete(0);
            if (mq.size() == 0) m_drained = 1'b1;
        end
    endtask

    task automatic check_head(input string tag);
        chk({tag, "_req"}, 80'(br_req_o), 80'(mq.size() != 0));
        if (mq.size() != 0) chk({tag, "_head"}, 80'(br_data_o), 80'(mq[0]));
    endtask

    initial begin
        logic [31:0] r;
        logic [31:0] p0, p1, v;
        brlite_out_t np;

        rst_i = 1'b1; cfg_en_i = 1'b0; cfg_we_i = 1'b0; cfg_addr_i = '0; cfg_data_i = '0;
        hermes_send_active_i = 1'b0; hermes_receive_active_i = 1'b0; hermes_receive_available_i = 1'b0;
        br_ack_i = 1'b0; br_svc_rx_i = 1'b0; br_svc_data_i = '0; br_mon_clear_ack_i = 1'b0;
        m_ovf = 1'b0; m_drained = 1'b0;
        repeat (3) cycle();
        rst_i = 1'b0;
        cycle();

        // Reset state
        chk("rst_cfg_data", 80'(cfg_data_o), 80'h0);
        chk("rst_br_req", 80'(br_req_o), 80'h0);
        chk("rst_br_data", 80'(br_data_o), 80'h0);
        chk("rst_irq", 80'(irq_o), 80'h0);
        chk("rst_start", 80'(hermes_start_o), 80'h0);
        chk("rst_op", 80'(hermes_operation_o), 80'(HERMES_SEND));
        chk("rst_mon_clear", 80'(br_mon_clear_o), 80'h0);
        chk("rst_mon_ptrs", 80'(br_mon_ptrs_o), 80'h0);
        chk("rst_svc_ack", 80'(br_svc_ack_o), 80'h0);

        // Info registers
        rd(ADDRESS_REG, r);      chk("address", 80'(r), 80'h0000_0102);
        rd(MANYCORE_SIZE, r);    chk("manycore_size", 80'(r), 80'h0003_0002);
        rd(TASKS_PER_PE_REG, r); chk("tasks_per_pe", 80'(r), 80'd1);
        rd(IMEM_PAGE_SZ_REG, r); chk("imem_page_sz", 80'(r), 80'd32768);
        rd(6'd30, r);            chk("undef_read", 80'(r), 80'h0);
        rd(BR_START, r);         chk("wo_read", 80'(r), 80'h0);

        // Fill with payloads 1..4, then overflow with a 5th
        for (int i = 1; i <= 4; i++) push_pkt(rand_pkt(32'(i)), 1'b0);
        chk("fill_req", 80'(br_req_o), 80'h1);
        rd(STATUS, r);
        chk("fill_count", 80'(r[15:8]), 80'(mq.size()));
        chk("fill_full", 80'(r[2]), 80'h1);
        push_pkt(rand_pkt(32'd5), 1'b0);
        rd(IRQ_STATUS, r);
        chk("ovf_sticky", 80'(r[IRQ_TX_OVF]), 80'(m_ovf));
        for (int i = 1; i <= 4; i++) begin
            chk("drain_payload", 80'(br_data_o.payload), 80'(i));
            check_head("drain");
            ack_only();
        end
        chk("drained_req", 80'(br_req_o), 80'h0);
        rd(IRQ_STATUS, r);
        chk("drained_sticky", 80'(r[IRQ_TX_DRAINED]), 80'(m_drained));
        wr(IRQ_CLEAR, 32'h18); m_ovf = 1'b0; m_drained = 1'b0;
        rd(IRQ_STATUS, r);
        chk("sticky_cleared", 80'(r[4:3]), 80'h0);

        // Full queue with simultaneous push and ack
        for (int i = 0; i < DEPTH; i++) push_pkt(rand_pkt($urandom), 1'b0);
        np = rand_pkt(32'hCAFE_0001);
        push_pkt(np, 1'b1);
        rd(STATUS, r);
        chk("fullpp_count", 80'(r[15:8]), 80'd4);
        rd(IRQ_STATUS, r);
        chk("fullpp_no_ovf", 80'(r[IRQ_TX_OVF]), 80'h0);
        for (int i = 0; i < DEPTH; i++) begin
            check_head("fullpp");
            ack_only();
        end
        chk("fullpp_last", 80'(np.payload), 80'hCAFE_0001);
        chk("fullpp_empty", 80'(br_req_o), 80'h0);

        // Randomized traffic against the model
        for (int it = 0; it < 40; it++) begin
            case ($urandom_range(0, 3))
                0: push_pkt(rand_pkt($urandom), 1'b0);
                1: push_pkt(rand_pkt($urandom), 1'b1);
                2: ack_only();
                default: cycle();
            endcase
            check_head("rand");
        end
        rd(STATUS, r);
        chk("rand_count", 80'(r[15:8]), 80'(mq.size()));
        rd(IRQ_STATUS, r);
        chk("rand_sticky", 80'(r[4:3]), 80'({m_ovf, m_drained}));

        // IRQ masking and clearing
        wr(IRQ_CLEAR, 32'h38); m_ovf = 1'b0; m_drained = 1'b0;
        while (mq.size() != 0) ack_only();
        wr(IRQ_MASK, 32'h10);
        chk("irq_masked_idle", 80'(irq_o), 80'h0);
        for (int i = 0; i < DEPTH + 1; i++) push_pkt(rand_pkt($urandom), 1'b0);
        chk("irq_ovf", 80'(irq_o), 80'(m_ovf));
        wr(IRQ_CLEAR, 32'h10); m_ovf = 1'b0;
        chk("irq_ovf_clr", 80'(irq_o), 80'h0);
        while (mq.size() != 0) ack_only();
        wr(IRQ_CLEAR, 32'h08); m_drained = 1'b0;
        push_pkt(rand_pkt($urandom), 1'b0);
        wr(IRQ_MASK, 32'h08);
        chk("irq_pre_setwin", 80'(irq_o), 80'h0);
        // Drain event in the same cycle as its clear: set wins
        br_ack_i = 1'b1;
        wr(IRQ_CLEAR, 32'h08);
        br_ack_i = 1'b0;
        mq.delete(0); m_drained = 1'b1;
        chk("irq_setwin", 80'(irq_o), 80'(m_drained));
        wr(IRQ_CLEAR, 32'h08); m_drained = 1'b0;
        chk("irq_setwin_clr", 80'(irq_o), 80'h0);
        wr(IRQ_MASK, 32'h01);
        hermes_receive_available_i = 1'b1;
        #1;
        chk("irq_live", 80'(irq_o), 80'h1);
        hermes_receive_available_i = 1'b0;
        wr(IRQ_MASK, 32'h0);

        // Hermes start pulse / busy rejection
        wr(HERMES_START, 32'h1);
        chk("start_pulse", 80'(hermes_start_o), 80'h1);
        cycle();
        chk("start_pulse_end", 80'(hermes_start_o), 80'h0);
        hermes_send_active_i = 1'b1;
        wr(HERMES_START, 32'h1);
        chk("start_suppressed", 80'(hermes_start_o), 80'h0);
        rd(STATUS, r);
        chk("busy_rej", 80'(r[5]), 80'h1);
        chk("status_send_active", 80'(r[0]), 80'h1);
        hermes_send_active_i = 1'b0;
        wr(IRQ_CLEAR, 32'h20);
        rd(STATUS, r);
        chk("busy_rej_clr", 80'(r[5]), 80'h0);
        v = $urandom;
        wr(HERMES_SIZE, v);
        chk("hermes_size_o", 80'(hermes_size_o), 80'(v));
        rd(HERMES_SIZE, r);
        chk("hermes_size_rd", 80'(r), 80'(v));
        wr(HERMES_OPERATION, 32'h1);
        chk("hermes_op", 80'(hermes_operation_o), 80'(HERMES_RECEIVE));

        // Monitor clear handshake and pointers
        wr(BR_MON_CLEAR, 32'd7);
        chk("mon_clear_set", 80'(br_mon_clear_o), 80'h1);
        chk("mon_task", 80'(br_mon_task_clear_o), 80'd7);
        wr(BR_MON_CLEAR, 32'd9);
        chk("mon_task_hold", 80'(br_mon_task_clear_o), 80'd7);
        br_mon_clear_ack_i = 1'b1;
        cycle();
        br_mon_clear_ack_i = 1'b0;
        chk("mon_clear_ack", 80'(br_mon_clear_o), 80'h0);
        p0 = $urandom; p1 = $urandom;
        wr(BR_MON_PTR_BASE, p0);
        wr(BR_MON_PTR_BASE + 6'd1, p1);
        chk("mon_ptrs", 80'(br_mon_ptrs_o), 80'({p1, p0}));
        wr(BR_MON_PTR_BASE + 6'(NMON), $urandom);
        chk("mon_ptrs_oob", 80'(br_mon_ptrs_o), 80'({p1, p0}));
        rd(BR_MON_PTR_BASE + 6'(NMON), r);
        chk("mon_ptr_oob_rd", 80'(r), 80'h0);
        rd(BR_MON_PTR_BASE + 6'd1, r);
        chk("mon_ptr1_rd", 80'(r), 80'(p1));

        // Service packet path
        br_svc_data_i = brlite_svc_t'({$urandom, $urandom, $urandom});
        br_svc_rx_i = 1'b1;
        rd(IRQ_STATUS, r);
        chk("svc_rx_live", 80'(r[IRQ_BR_SVC_RX]), 80'h1);
        rd(BR_SVC_PAYLOAD, r);
        chk("svc_payload", 80'(r), 80'(br_svc_data_i.payload));
        rd(BR_SVC_PRODUCER, r);
        chk("svc_producer", 80'(r), 80'(br_svc_data_i.producer));
        wr(BR_SVC_POP, 32'h1);
        chk("svc_ack", 80'(br_svc_ack_o), 80'h1);
        wr(BR_SVC_POP, 32'h1);
        chk("svc_ack_ignored", 80'(br_svc_ack_o), 80'h0);
        br_svc_rx_i = 1'b0;

        // Reset in the middle of a transfer
        push_pkt(rand_pkt($urandom), 1'b0);
        push_pkt(rand_pkt($urandom), 1'b0);
        chk("pre_rst_req", 80'(br_req_o), 80'h1);
        rst_i = 1'b1;
        cycle();
        rst_i = 1'b0;
        mq.delete();
        chk("mid_rst_req", 80'(br_req_o), 80'h0);
        rd(STATUS, r);
        chk("mid_rst_count", 80'(r[15:8]), 80'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
